// File: rtl/motor_ctrl_pkg.sv
// Shared constants for the motor ramp sequencer: register map, channel
// state codes, H-bridge input codes and default widths.
package motor_ctrl_pkg;

  localparam int DUTY_W_DEF = 10;
  localparam int DIV_W_DEF  = 16;

  // Register word index (PADDR[4:2])
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_TGT_L  = 3'd1;
  localparam logic [2:0] REG_TGT_R  = 3'd2;
  localparam logic [2:0] REG_RAMP   = 3'd3;
  localparam logic [2:0] REG_DEAD   = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;

  // Channel states, also the value reported in STATUS
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_RDOWN = 2'd2;
  localparam logic [1:0] ST_DEAD  = 2'd3;

  // H-bridge input pair codes
  localparam logic [1:0] AB_FWD   = 2'b10;
  localparam logic [1:0] AB_REV   = 2'b01;
  localparam logic [1:0] AB_COAST = 2'b00;

  // Bridge drive code for a direction bit (1 = reverse)
  function automatic logic [1:0] ab_for_dir(input logic dir);
    if (dir) begin
      return AB_REV;
    end else begin
      return AB_FWD;
    end
  endfunction

endpackage

// File: rtl/motor_ramp_sequencer_if.sv
// APB3 completer-side bus bundle for the motor ramp sequencer.
interface motor_ramp_sequencer_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/motor_ramp_channel.sv
// One motor side: ramps live duty toward target, and on a direction change
// ramps to zero, coasts for the dead time, then restarts the other way.
module motor_ramp_channel
  import motor_ctrl_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_en,
  input  logic              tick,
  input  logic [7:0]        step,
  input  logic [DIV_W-1:0]  dead_cycles,
  input  logic [DUTY_W-1:0] tgt_duty,
  input  logic              tgt_dir,
  output logic [DUTY_W-1:0] duty,
  output logic [1:0]        ab,
  output logic [1:0]        st
);

  // Wide enough for duty+step without wrap, even when DUTY_W is below 8
  localparam int AW = (DUTY_W + 1 > 9) ? DUTY_W + 1 : 9;

  logic [1:0]        state_r, state_n_s;
  logic [DUTY_W-1:0] duty_r, duty_n_s;
  logic [1:0]        ab_r, ab_n_s;
  logic              dir_r, dir_n_s;
  logic [DIV_W-1:0]  dead_cnt_r, dead_n_s;

  logic [AW-1:0]     duty_x_s, tgt_x_s, step_x_s, sum_s, diff_s;
  logic              borrow_s;
  logic [DUTY_W-1:0] approach_s, rdown_s;

  // Widened operands so carry and borrow are visible
  always_comb begin
    duty_x_s = AW'(duty_r);
    tgt_x_s  = AW'(tgt_duty);
    step_x_s = AW'(step);
    sum_s    = duty_x_s + step_x_s;
    diff_s   = duty_x_s - step_x_s;
    borrow_s = (step_x_s > duty_x_s);
  end

  // One RUN tick toward the target, clamped so it never overshoots
  always_comb begin
    approach_s = duty_r;
    if (duty_x_s < tgt_x_s) begin
      if (sum_s > tgt_x_s) begin
        approach_s = tgt_duty;
      end else begin
        approach_s = sum_s[DUTY_W-1:0];
      end
    end else if (duty_x_s > tgt_x_s) begin
      if (borrow_s || (diff_s < tgt_x_s)) begin
        approach_s = tgt_duty;
      end else begin
        approach_s = diff_s[DUTY_W-1:0];
      end
    end else begin
      approach_s = duty_r;
    end
  end

  // One RDOWN tick, floored at zero
  always_comb begin
    if (borrow_s) begin
      rdown_s = {DUTY_W{1'b0}};
    end else begin
      rdown_s = diff_s[DUTY_W-1:0];
    end
  end

  // Next-state logic; a dropped run enable overrides everything
  always_comb begin
    state_n_s = state_r;
    duty_n_s  = duty_r;
    ab_n_s    = ab_r;
    dir_n_s   = dir_r;
    dead_n_s  = dead_cnt_r;
    if (!run_en) begin
      state_n_s = ST_IDLE;
      duty_n_s  = {DUTY_W{1'b0}};
      ab_n_s    = AB_COAST;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_n_s = ST_RUN;
          dir_n_s   = tgt_dir;
          ab_n_s    = ab_for_dir(tgt_dir);
          duty_n_s  = {DUTY_W{1'b0}};
        end
        ST_RUN: begin
          if (tgt_dir != dir_r) begin
            state_n_s = ST_RDOWN;
          end else if (tick) begin
            duty_n_s = approach_s;
          end else begin
            duty_n_s = duty_r;
          end
        end
        ST_RDOWN: begin
          if (tgt_dir == dir_r) begin
            state_n_s = ST_RUN;
          end else if (duty_r == {DUTY_W{1'b0}}) begin
            state_n_s = ST_DEAD;
            dead_n_s  = dead_cycles;
            ab_n_s    = AB_COAST;
          end else if (tick) begin
            duty_n_s = rdown_s;
          end else begin
            duty_n_s = duty_r;
          end
        end
        ST_DEAD: begin
          duty_n_s = {DUTY_W{1'b0}};
          if (dead_cnt_r == {DIV_W{1'b0}}) begin
            state_n_s = ST_RUN;
            dir_n_s   = tgt_dir;
            ab_n_s    = ab_for_dir(tgt_dir);
          end else begin
            dead_n_s = dead_cnt_r - DIV_W'(1);
            ab_n_s   = AB_COAST;
          end
        end
        default: begin
          state_n_s = ST_IDLE;
          duty_n_s  = {DUTY_W{1'b0}};
          ab_n_s    = AB_COAST;
        end
      endcase
    end
  end

  // Channel state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      duty_r     <= {DUTY_W{1'b0}};
      ab_r       <= AB_COAST;
      dir_r      <= 1'b0;
      dead_cnt_r <= {DIV_W{1'b0}};
    end else begin
      state_r    <= state_n_s;
      duty_r     <= duty_n_s;
      ab_r       <= ab_n_s;
      dir_r      <= dir_n_s;
      dead_cnt_r <= dead_n_s;
    end
  end

  assign duty = duty_r;
  assign ab   = ab_r;
  assign st   = state_r;

endmodule

// File: rtl/motor_ramp_sequencer.sv
// APB3 register file, shared ramp-tick prescaler and the two motor channels.
// The RAMP div field is 16 bits wide on the bus; DIV_W is expected <= 16.
module motor_ramp_sequencer
  import motor_ctrl_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic                   PCLK,
  input  logic                   PRESERN,
  motor_ramp_sequencer_if.slave  apb,
  output logic [DUTY_W-1:0]      duty_left,
  output logic [DUTY_W-1:0]      duty_right,
  output logic [3:0]             inputsAB
);

  logic              ctrl_en_r, ctrl_estop_r;
  logic [DUTY_W-1:0] tgt_l_duty_r, tgt_r_duty_r;
  logic              tgt_l_dir_r, tgt_r_dir_r;
  logic [DIV_W-1:0]  ramp_div_r;
  logic [7:0]        ramp_step_r;
  logic [DIV_W-1:0]  dead_r;
  logic [DIV_W-1:0]  presc_r;

  logic [2:0]        reg_idx_s;
  logic              mapped_s, wr_s, tick_s, run_en_s;
  logic [31:0]       rdata_s;
  logic [DUTY_W-1:0] duty_l_s, duty_r_s;
  logic [1:0]        ab_l_s, ab_r_s, st_l_s, st_r_s;
  logic              unused_bus_s;

  assign reg_idx_s    = apb.PADDR[4:2];
  assign mapped_s     = (reg_idx_s <= REG_STATUS);
  assign wr_s         = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign run_en_s     = ctrl_en_r & ~ctrl_estop_r;
  assign tick_s       = ctrl_en_r & (presc_r == ramp_div_r);
  assign unused_bus_s = ^{apb.PADDR, apb.PWDATA};

  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = apb.PSEL & apb.PENABLE & ~mapped_s;
  assign apb.PRDATA  = rdata_s;

  // Register writes; STATUS and unmapped offsets leave state untouched
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      ctrl_en_r    <= 1'b0;
      ctrl_estop_r <= 1'b0;
      tgt_l_duty_r <= {DUTY_W{1'b0}};
      tgt_l_dir_r  <= 1'b0;
      tgt_r_duty_r <= {DUTY_W{1'b0}};
      tgt_r_dir_r  <= 1'b0;
      ramp_div_r   <= {DIV_W{1'b0}};
      ramp_step_r  <= 8'd0;
      dead_r       <= {DIV_W{1'b0}};
    end else if (wr_s) begin
      case (reg_idx_s)
        REG_CTRL: begin
          ctrl_en_r    <= apb.PWDATA[0];
          ctrl_estop_r <= apb.PWDATA[1];
        end
        REG_TGT_L: begin
          tgt_l_duty_r <= apb.PWDATA[DUTY_W-1:0];
          tgt_l_dir_r  <= apb.PWDATA[31];
        end
        REG_TGT_R: begin
          tgt_r_duty_r <= apb.PWDATA[DUTY_W-1:0];
          tgt_r_dir_r  <= apb.PWDATA[31];
        end
        REG_RAMP: begin
          ramp_div_r  <= apb.PWDATA[DIV_W-1:0];
          ramp_step_r <= apb.PWDATA[23:16];
        end
        REG_DEAD: begin
          dead_r <= apb.PWDATA[DIV_W-1:0];
        end
        default: begin
          ctrl_en_r <= ctrl_en_r;
        end
      endcase
    end
  end

  // Ramp-tick prescaler: counts 0..div, held clear while disabled
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      presc_r <= {DIV_W{1'b0}};
    end else if (!ctrl_en_r) begin
      presc_r <= {DIV_W{1'b0}};
    end else if (presc_r == ramp_div_r) begin
      presc_r <= {DIV_W{1'b0}};
    end else begin
      presc_r <= presc_r + DIV_W'(1);
    end
  end

  // Combinational read mux; unmapped offsets read as zero
  always_comb begin
    rdata_s = 32'd0;
    case (reg_idx_s)
      REG_CTRL: begin
        rdata_s[1:0] = {ctrl_estop_r, ctrl_en_r};
      end
      REG_TGT_L: begin
        rdata_s[DUTY_W-1:0] = tgt_l_duty_r;
        rdata_s[31]         = tgt_l_dir_r;
      end
      REG_TGT_R: begin
        rdata_s[DUTY_W-1:0] = tgt_r_duty_r;
        rdata_s[31]         = tgt_r_dir_r;
      end
      REG_RAMP: begin
        rdata_s[DIV_W-1:0] = ramp_div_r;
        rdata_s[23:16]     = ramp_step_r;
      end
      REG_DEAD: begin
        rdata_s[DIV_W-1:0] = dead_r;
      end
      REG_STATUS: begin
        rdata_s[DUTY_W-1:0]  = duty_l_s;
        rdata_s[DUTY_W+15:16] = duty_r_s;
        rdata_s[31:30]       = st_l_s;
        rdata_s[29:28]       = st_r_s;
      end
      default: begin
        rdata_s = 32'd0;
      end
    endcase
  end

  motor_ramp_channel #(.DUTY_W(DUTY_W), .DIV_W(DIV_W)) u_left (
    .clk         (PCLK),
    .rst_n       (PRESERN),
    .run_en      (run_en_s),
    .tick        (tick_s),
    .step        (ramp_step_r),
    .dead_cycles (dead_r),
    .tgt_duty    (tgt_l_duty_r),
    .tgt_dir     (tgt_l_dir_r),
    .duty        (duty_l_s),
    .ab          (ab_l_s),
    .st          (st_l_s)
  );

  motor_ramp_channel #(.DUTY_W(DUTY_W), .DIV_W(DIV_W)) u_right (
    .clk         (PCLK),
    .rst_n       (PRESERN),
    .run_en      (run_en_s),
    .tick        (tick_s),
    .step        (ramp_step_r),
    .dead_cycles (dead_r),
    .tgt_duty    (tgt_r_duty_r),
    .tgt_dir     (tgt_r_dir_r),
    .duty        (duty_r_s),
    .ab          (ab_r_s),
    .st          (st_r_s)
  );

  assign duty_left  = duty_l_s;
  assign duty_right = duty_r_s;
  assign inputsAB   = {ab_r_s, ab_l_s};

endmodule
